// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : RV32I memory-access pipeline stage. Accepts one execute result
//            per cycle, runs loads/stores over a req/ack data bus with
//            byte/halfword lane steering, and registers the writeback bundle.
//            Flags misaligned/unsupported accesses and bus timeouts.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            ex_*_i               - instruction presented by execute
//            stall_o              - execute must hold while an access is open
//            bus_*_o / bus_*_i    - word-addressed data bus, req/ack handshake
//            wb_*_o               - registered bundle feeding the writeback mux
//            misalign_o, bus_err_o- fault pulses aligned with wb_valid_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // execute side
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_4_i,
  input  logic [31:0] ex_alu_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [1:0]  ex_mem_op_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_we_i,
  output logic        stall_o,
  // data bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  // writeback side
  output logic        wb_valid_o,
  output logic [31:0] wb_pc_4_o,
  output logic [31:0] wb_alu_o,
  output logic [31:0] wb_mem_o,
  output logic [1:0]  wb_sel_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_we_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  // The counter only has to reach MAX_WAIT-1.
  localparam int                 C_CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;

  // fields of the accepted instruction, needed while the access is open
  logic [31:0] lat_pc_4_q,   lat_pc_4_d;
  logic [31:0] lat_alu_q,    lat_alu_d;
  logic [2:0]  lat_funct3_q, lat_funct3_d;
  logic [1:0]  lat_wb_sel_q, lat_wb_sel_d;
  logic [4:0]  lat_rd_q,     lat_rd_d;
  logic        lat_reg_we_q, lat_reg_we_d;
  logic        lat_store_q,  lat_store_d;

  logic        bus_req_q,   bus_req_d;
  logic        bus_we_q,    bus_we_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q,    bus_be_d;

  logic        wb_valid_q,  wb_valid_d;
  logic [31:0] wb_pc_4_q,   wb_pc_4_d;
  logic [31:0] wb_alu_q,    wb_alu_d;
  logic [31:0] wb_mem_q,    wb_mem_d;
  logic [1:0]  wb_sel_q,    wb_sel_d;
  logic [4:0]  wb_rd_q,     wb_rd_d;
  logic        wb_reg_we_q, wb_reg_we_d;
  logic        misalign_q,  misalign_d;
  logic        bus_err_q,   bus_err_d;

  // --------------------------------------------------------------------------
  // Decode of the instruction currently presented by execute
  // --------------------------------------------------------------------------
  logic        ex_is_mem;
  logic        ex_is_store;
  logic [1:0]  ex_size;
  logic        ex_fault;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;

  assign ex_is_mem   = (ex_mem_op_i == 2'b01) || (ex_mem_op_i == 2'b10);
  assign ex_is_store = (ex_mem_op_i == 2'b10);
  assign ex_size     = ex_funct3_i[1:0];

  // funct3 011/110/111 have no RV32I load/store meaning; size 11 is always
  // one of them, so only halfword and word need an alignment test.
  assign ex_fault = (ex_funct3_i == 3'b011) || (ex_funct3_i[2:1] == 2'b11) ||
                    ((ex_size == 2'b01) && ex_alu_i[0]) ||
                    ((ex_size == 2'b10) && (ex_alu_i[1:0] != 2'b00));

  always_comb begin
    ex_be    = 4'b1111;
    ex_wdata = ex_store_data_i;
    case (ex_size)
      2'b00: begin
        ex_be    = 4'b0001 << ex_alu_i[1:0];
        ex_wdata = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        ex_be    = 4'b0011 << ex_alu_i[1:0];
        ex_wdata = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        ex_be    = 4'b1111;
        ex_wdata = ex_store_data_i;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load data alignment and extension
  // --------------------------------------------------------------------------
  logic [31:0] rdata_shift;
  logic [31:0] load_data;

  assign rdata_shift = bus_rdata_i >> {lat_alu_q[1:0], 3'b000};

  always_comb begin
    load_data = rdata_shift;
    case (lat_funct3_q)
      3'b000:  load_data = {{24{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_data = {24'h000000, rdata_shift[7:0]};
      3'b101:  load_data = {16'h0000,   rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_pc_4_d   = lat_pc_4_q;
    lat_alu_d    = lat_alu_q;
    lat_funct3_d = lat_funct3_q;
    lat_wb_sel_d = lat_wb_sel_q;
    lat_rd_d     = lat_rd_q;
    lat_reg_we_d = lat_reg_we_q;
    lat_store_d  = lat_store_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    // a bubble unless something retires; payload fields hold their value
    wb_valid_d   = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    wb_pc_4_d    = wb_pc_4_q;
    wb_alu_d     = wb_alu_q;
    wb_mem_d     = wb_mem_q;
    wb_sel_d     = wb_sel_q;
    wb_rd_d      = wb_rd_q;
    wb_reg_we_d  = wb_reg_we_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          lat_pc_4_d   = ex_pc_4_i;
          lat_alu_d    = ex_alu_i;
          lat_funct3_d = ex_funct3_i;
          lat_wb_sel_d = ex_wb_sel_i;
          lat_rd_d     = ex_rd_i;
          lat_reg_we_d = ex_reg_we_i;
          lat_store_d  = ex_is_store;
          if (!ex_is_mem || ex_fault) begin
            // retires straight away; a faulting access never reaches the bus
            wb_valid_d  = 1'b1;
            wb_pc_4_d   = ex_pc_4_i;
            wb_alu_d    = ex_alu_i;
            wb_mem_d    = 32'h0000_0000;
            wb_sel_d    = ex_wb_sel_i;
            wb_rd_d     = ex_rd_i;
            wb_reg_we_d = ex_reg_we_i && !ex_is_mem;
            misalign_d  = ex_is_mem;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = ex_is_store;
            bus_addr_d  = {ex_alu_i[31:2], 2'b00};
            bus_be_d    = ex_be;
            bus_wdata_d = ex_wdata;
          end
        end
      end

      S_WAIT: begin
        // ack is checked before the limit so a last-cycle ack still completes
        if (bus_ack_i || (cnt_q == C_CNT_LAST)) begin
          state_d     = S_IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          wb_valid_d  = 1'b1;
          wb_pc_4_d   = lat_pc_4_q;
          wb_alu_d    = lat_alu_q;
          wb_sel_d    = lat_wb_sel_q;
          wb_rd_d     = lat_rd_q;
          if (bus_ack_i) begin
            wb_mem_d    = lat_store_q ? 32'h0000_0000 : load_data;
            wb_reg_we_d = lat_reg_we_q;
          end else begin
            wb_mem_d    = 32'h0000_0000;
            wb_reg_we_d = 1'b0;
            bus_err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lat_pc_4_q   <= 32'h0000_0000;
      lat_alu_q    <= 32'h0000_0000;
      lat_funct3_q <= 3'b000;
      lat_wb_sel_q <= 2'b00;
      lat_rd_q     <= 5'd0;
      lat_reg_we_q <= 1'b0;
      lat_store_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_wdata_q  <= 32'h0000_0000;
      bus_be_q     <= 4'b0000;
      wb_valid_q   <= 1'b0;
      wb_pc_4_q    <= 32'h0000_0000;
      wb_alu_q     <= 32'h0000_0000;
      wb_mem_q     <= 32'h0000_0000;
      wb_sel_q     <= 2'b00;
      wb_rd_q      <= 5'd0;
      wb_reg_we_q  <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_pc_4_q   <= lat_pc_4_d;
      lat_alu_q    <= lat_alu_d;
      lat_funct3_q <= lat_funct3_d;
      lat_wb_sel_q <= lat_wb_sel_d;
      lat_rd_q     <= lat_rd_d;
      lat_reg_we_q <= lat_reg_we_d;
      lat_store_q  <= lat_store_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      wb_valid_q   <= wb_valid_d;
      wb_pc_4_q    <= wb_pc_4_d;
      wb_alu_q     <= wb_alu_d;
      wb_mem_q     <= wb_mem_d;
      wb_sel_q     <= wb_sel_d;
      wb_rd_q      <= wb_rd_d;
      wb_reg_we_q  <= wb_reg_we_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall_o     = (state_q == S_WAIT);
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_pc_4_o   = wb_pc_4_q;
  assign wb_alu_o    = wb_alu_q;
  assign wb_mem_o    = wb_mem_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_reg_we_o = wb_reg_we_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

`default_nettype wire
